// File: rtl/line_buffer_pingpong.sv
// rtl/line_buffer_pingpong.sv - double-buffered scanline palette-index buffer
// Writer composes into the back bank; display reads the front bank; line_swap exchanges them.
module line_buffer_pingpong #(
  parameter int DATA_W          = 4,
  parameter int LINE_LEN        = 640,
  parameter int ADDR_W          = $clog2(LINE_LEN),
  parameter int BG_INDEX        = 0,
  parameter bit TRANSPARENT_EN  = 1'b1,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              line_swap,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              front_bank,
  output logic              clear_busy,
  output logic              overrun
);

  localparam logic [DATA_W-1:0] BG_VAL   = DATA_W'(BG_INDEX);
  localparam logic [DATA_W-1:0] TR_VAL   = DATA_W'(TRANSPARENT_IDX);
  localparam logic [ADDR_W:0]   LEN_VAL  = (ADDR_W+1)'(LINE_LEN);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LINE_LEN - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic                front_bank_q, front_bank_d;
  logic                overrun_q, overrun_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic [DATA_W-1:0]   mem [0:1][0:LINE_LEN-1];

  logic                back_bank;
  logic                wr_fire;
  logic                wr_in_range;
  logic                wr_transparent;
  logic                rd_in_range;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  always_comb begin
    wr_ready       = (state_q == ST_READY);
    clear_busy     = (state_q == ST_CLEAR);
    back_bank      = ~front_bank_q;
    wr_fire        = wr_valid && wr_ready;
    wr_in_range    = ({1'b0, wr_addr} < LEN_VAL);
    wr_transparent = TRANSPARENT_EN && (wr_data == TR_VAL);
    rd_in_range    = ({1'b0, rd_addr} < LEN_VAL);

    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    front_bank_d = front_bank_q;
    overrun_d    = overrun_q;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = BG_VAL;
        if (clr_ptr_q == LAST_PTR) begin
          state_d = ST_READY;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      ST_READY: begin
        // Discarded writes still handshake; only the RAM update is suppressed.
        if (wr_fire && wr_in_range && !wr_transparent) begin
          mem_we    = 1'b1;
          mem_waddr = wr_addr;
          mem_wdata = wr_data;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    // Swap overrides everything; a swap mid-clear promotes a half-cleared bank.
    if (line_swap) begin
      front_bank_d = ~front_bank_q;
      clr_ptr_d    = '0;
      state_d      = ST_CLEAR;
      if (state_q == ST_CLEAR) begin
        overrun_d = 1'b1;
      end
    end

    rd_data_d = rd_in_range ? mem[front_bank_q][rd_addr] : BG_VAL;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_CLEAR;
      clr_ptr_q    <= '0;
      front_bank_q <= 1'b0;
      overrun_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      front_bank_q <= front_bank_d;
      overrun_q    <= overrun_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Write uses the pre-swap back bank, so a write coincident with line_swap lands in the new front.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[back_bank][mem_waddr] <= mem_wdata;
    end
  end

  assign rd_data    = rd_data_q;
  assign front_bank = front_bank_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_line_buffer_pingpong.sv
// tb/tb_line_buffer_pingpong.sv - directed vector bench for line_buffer_pingpong
// Two instances share stimulus; the second has transparency disabled.
module tb_line_buffer_pingpong;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 10;
  localparam int BG     = 12;

  localparam logic [1:0] K_WR   = 2'd0;
  localparam logic [1:0] K_SWAP = 2'd1;
  localparam logic [1:0] K_RD   = 2'd2;
  localparam logic [1:0] K_WAIT = 2'd3;

  typedef struct {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp;
    logic [DATA_W-1:0] exp2;
  } vec_t;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              line_swap;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_ready, wr_ready2;
  logic [DATA_W-1:0] rd_data, rd_data2;
  logic              front_bank, front_bank2;
  logic              clear_busy, clear_busy2;
  logic              overrun, overrun2;

  int n_vec = 0;
  int n_bad = 0;
  logic exp_front = 1'b0;
  vec_t vecs[$];

  always #5 Clk = ~Clk;

  line_buffer_pingpong #(
    .DATA_W(DATA_W), .LINE_LEN(640), .BG_INDEX(BG), .TRANSPARENT_EN(1'b1), .TRANSPARENT_IDX(0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .line_swap(line_swap), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .front_bank(front_bank), .clear_busy(clear_busy), .overrun(overrun)
  );

  line_buffer_pingpong #(
    .DATA_W(DATA_W), .LINE_LEN(640), .BG_INDEX(BG), .TRANSPARENT_EN(1'b0), .TRANSPARENT_IDX(0)
  ) dut_nt (
    .Clk(Clk), .Reset(Reset), .line_swap(line_swap), .wr_valid(wr_valid), .wr_ready(wr_ready2),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data2),
    .front_bank(front_bank2), .clear_busy(clear_busy2), .overrun(overrun2)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (wr_ready !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk("wait_ready", {31'd0, wr_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wait_ready();
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_swap();
    line_swap = 1'b1;
    tick();
    line_swap = 1'b0;
    exp_front = ~exp_front;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd0);
    chk({tag, "_clear_busy"}, {31'd0, clear_busy}, 32'd1);
    chk({tag, "_rd_data"}, {28'd0, rd_data}, 32'd0);
    chk({tag, "_front_bank"}, {31'd0, front_bank}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; line_swap = 1'b0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;

    // line 1 into bank 1, then line 2 into bank 0
    vecs.push_back('{K_WR,   10'd5,   4'h7, 4'h0, 4'h0});
    vecs.push_back('{K_WR,   10'd639, 4'hA, 4'h0, 4'h0});
    vecs.push_back('{K_WR,   10'd10,  4'h3, 4'h0, 4'h0});
    vecs.push_back('{K_WR,   10'd10,  4'h0, 4'h0, 4'h0});
    vecs.push_back('{K_WR,   10'd700, 4'h1, 4'h0, 4'h0});
    vecs.push_back('{K_SWAP, 10'd0,   4'h0, 4'h0, 4'h0});
    vecs.push_back('{K_RD,   10'd5,   4'h0, 4'h7, 4'h7});
    vecs.push_back('{K_RD,   10'd639, 4'h0, 4'hA, 4'hA});
    vecs.push_back('{K_RD,   10'd6,   4'h0, 4'hC, 4'hC});
    vecs.push_back('{K_RD,   10'd10,  4'h0, 4'h3, 4'h0});
    vecs.push_back('{K_RD,   10'd700, 4'h0, 4'hC, 4'hC});
    vecs.push_back('{K_WAIT, 10'd0,   4'h0, 4'h0, 4'h0});
    vecs.push_back('{K_WR,   10'd5,   4'h1, 4'h0, 4'h0});
    vecs.push_back('{K_SWAP, 10'd0,   4'h0, 4'h0, 4'h0});
    vecs.push_back('{K_RD,   10'd5,   4'h0, 4'h1, 4'h1});
    vecs.push_back('{K_RD,   10'd10,  4'h0, 4'hC, 4'hC});
    vecs.push_back('{K_RD,   10'd639, 4'h0, 4'hC, 4'hC});

    repeat (3) tick();
    chk_reset_vals("in_reset");
    Reset = 1'b0;
    chk_reset_vals("post_reset");
    repeat (639) tick();
    chk("clear_len_low", {31'd0, wr_ready}, 32'd0);
    tick();
    chk("clear_len_high", {31'd0, wr_ready}, 32'd1);
    chk("clear_done_busy", {31'd0, clear_busy}, 32'd0);

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        K_WR:   do_write(vecs[i].addr, vecs[i].data);
        K_SWAP: begin
          do_swap();
          chk("swap_front", {31'd0, front_bank}, {31'd0, exp_front});
        end
        K_WAIT: wait_ready();
        default: begin
          rd_addr = vecs[i].addr;
          tick();
          chk($sformatf("rd%0d_addr%0d", i, vecs[i].addr), {28'd0, rd_data}, {28'd0, vecs[i].exp});
          chk($sformatf("rd%0d_notr", i), {28'd0, rd_data2}, {28'd0, vecs[i].exp2});
        end
      endcase
    end

    // write coincident with swap lands in the newly promoted front bank
    wait_ready();
    wr_valid = 1'b1; wr_addr = 10'd3; wr_data = 4'h5; line_swap = 1'b1;
    tick();
    wr_valid = 1'b0; line_swap = 1'b0; exp_front = ~exp_front;
    chk("coinc_ready_drop", {31'd0, wr_ready}, 32'd0);
    chk("coinc_busy", {31'd0, clear_busy}, 32'd1);
    rd_addr = 10'd3;
    tick();
    chk("coinc_rd3", {28'd0, rd_data}, 32'h5);
    chk("coinc_front", {31'd0, front_bank}, {31'd0, exp_front});

    // overrun: second swap 100 cycles into the clear
    wait_ready();
    chk("overrun_pre", {31'd0, overrun}, 32'd0);
    do_swap();
    repeat (100) tick();
    chk("overrun_mid", {31'd0, overrun}, 32'd0);
    do_swap();
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    repeat (639) tick();
    chk("overrun_clear_low", {31'd0, wr_ready}, 32'd0);
    tick();
    chk("overrun_clear_high", {31'd0, wr_ready}, 32'd1);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);

    // asynchronous reset mid-clear
    do_swap();
    repeat (50) tick();
    Reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    tick();
    Reset = 1'b0;
    repeat (640) tick();
    chk("restart_ready", {31'd0, wr_ready}, 32'd1);
    chk("restart_front", {31'd0, front_bank}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
